// File: rtl/syncreadmem_arbiter_pkg.sv
// Shared types for the SyncReadMem arbiter.
// ARB_INIT : zero-fill sweep in progress, requesters are held off.
// ARB_IDLE : normal operation, one round-robin grant per cycle.
package syncreadmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_INIT = 1'b0,
    ARB_IDLE = 1'b1
  } arb_state_e;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/syncreadmem_arbiter_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid       : per-requester request lines
//   advance     : arbitration enabled this cycle (no grant when low)
//   grant       : one-hot grant, or zero
//   grant_idx   : index of the granted requester (0 when no grant)
// The arbiter picks the first valid requester at or after r_rr_ptr. After
// a grant the pointer moves to the slot just past the winner.
module rr_arbiter
  import syncreadmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;
  int                 w_pos;

  // Search the requesters starting at the pointer, wrapping once.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    if (advance) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_pos = int'(r_rr_ptr) + i;
        if (w_pos >= NUM_REQ) begin
          w_pos = w_pos - NUM_REQ;
        end else begin
          w_pos = w_pos;
        end
        if (!w_found && valid[w_pos]) begin
          w_found        = 1'b1;
          w_grant[w_pos] = 1'b1;
          w_idx          = IDX_W'(w_pos);
        end else begin
          w_found = w_found;
        end
      end
    end else begin
      w_found = 1'b0;
    end
  end

  // Move the pointer past the winner; hold it when nothing was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      if (w_idx == IDX_W'(NUM_REQ - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_idx + IDX_W'(1);
      end
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  assign grant     = w_grant;
  assign grant_idx = w_idx;

endmodule

// File: rtl/syncreadmem_arbiter.sv
// Shares one synchronous-read memory between NUM_REQ requesters and
// zero-fills it after reset (when INIT_EN) or on a clear pulse.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   clear                : re-run the zero-fill sweep (accepted in IDLE only)
//   init_done            : high while in ARB_IDLE
//   req_valid/req_ready  : per-requester handshake (ready is one-hot or zero)
//   req_wen/addr/mask/wdata : per-requester access description
//   rsp_valid            : read data valid, one bit per requester
//   rsp_rdata            : read data broadcast to all requesters
//   mem_wen/waddr/cs/wdata : memory write channel
//   mem_ren/raddr        : memory read channel
//   mem_rdata            : memory read data (one-cycle latency)
// At most one access (read or masked write) goes out per cycle, so the
// memory never sees a read and a write together.
module syncreadmem_arbiter
  import syncreadmem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DEEPTH      = 2048,
  parameter int DATA_WIDTH  = 2,
  parameter int WMASK_WIDTH = 4,
  parameter int ADDR_WIDTH  = $clog2(DEEPTH),
  parameter bit INIT_EN     = 1'b1
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                clear,
  output logic                                                init_done,
  input  logic [NUM_REQ-1:0]                                  req_valid,
  output logic [NUM_REQ-1:0]                                  req_ready,
  input  logic [NUM_REQ-1:0]                                  req_wen,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]                  req_addr,
  input  logic [NUM_REQ-1:0][WMASK_WIDTH-1:0]                 req_mask,
  input  logic [NUM_REQ-1:0][WMASK_WIDTH-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                                  rsp_valid,
  output logic [WMASK_WIDTH-1:0][DATA_WIDTH-1:0]              rsp_rdata,
  output logic                                                mem_wen,
  output logic [ADDR_WIDTH-1:0]                               mem_waddr,
  output logic [WMASK_WIDTH-1:0]                              mem_cs,
  output logic [WMASK_WIDTH-1:0][DATA_WIDTH-1:0]              mem_wdata,
  output logic                                                mem_ren,
  output logic [ADDR_WIDTH-1:0]                               mem_raddr,
  input  logic [WMASK_WIDTH-1:0][DATA_WIDTH-1:0]              mem_rdata
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic                r_init_done;
  logic [NUM_REQ-1:0]  r_rsp_sel;

  logic                w_arb_en;
  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_grant_any;
  logic                w_grant_rd;

  // Arbitration runs only in IDLE, never on a clear cycle, never in reset.
  assign w_arb_en    = rst_n & (r_state == ARB_IDLE) & ~clear;
  assign w_grant_any = |w_grant;
  assign w_grant_rd  = w_grant_any & ~req_wen[w_grant_idx];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .advance   (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // State machine and zero-fill address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT_EN ? ARB_INIT : ARB_IDLE;
      r_init_done <= INIT_EN ? 1'b0 : 1'b1;
      r_init_addr <= '0;
    end else begin
      case (r_state)
        ARB_INIT: begin
          // Equality compare, so a non-power-of-2 depth stops at the last word.
          if (r_init_addr == ADDR_WIDTH'(DEEPTH - 1)) begin
            r_state     <= ARB_IDLE;
            r_init_done <= 1'b1;
            r_init_addr <= '0;
          end else begin
            r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
          end
        end
        ARB_IDLE: begin
          if (clear) begin
            r_state     <= ARB_INIT;
            r_init_done <= 1'b0;
            r_init_addr <= '0;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          r_state     <= ARB_INIT;
          r_init_done <= 1'b0;
          r_init_addr <= '0;
        end
      endcase
    end
  end

  // Remember which requester owns the read data arriving next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_sel <= '0;
    end else if (w_grant_rd) begin
      r_rsp_sel <= w_grant;
    end else begin
      r_rsp_sel <= '0;
    end
  end

  // Memory channel mux: sweep write, granted write, granted read, or idle.
  always_comb begin
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_cs    = '0;
    mem_wdata = '0;
    mem_ren   = 1'b0;
    mem_raddr = '0;
    // rst_n gating keeps both enables low while reset is held.
    if (rst_n && (r_state == ARB_INIT)) begin
      mem_wen   = 1'b1;
      mem_waddr = r_init_addr;
      mem_cs    = '1;
    end else if (w_grant_any) begin
      if (req_wen[w_grant_idx]) begin
        mem_wen   = 1'b1;
        mem_waddr = req_addr[w_grant_idx];
        mem_cs    = req_mask[w_grant_idx];
        mem_wdata = req_wdata[w_grant_idx];
      end else begin
        mem_ren   = 1'b1;
        mem_raddr = req_addr[w_grant_idx];
      end
    end else begin
      mem_wen = 1'b0;
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_sel;
  assign rsp_rdata = mem_rdata;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_syncreadmem_arbiter.sv
// Directed bench for syncreadmem_arbiter with a 16-word memory model.
module tb_syncreadmem_arbiter;

  localparam int NR = 2;
  localparam int DP = 16;
  localparam int DW = 2;
  localparam int MW = 4;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic fill  = 1'b1;

  logic [NR-1:0]                 req_valid;
  logic [NR-1:0]                 req_wen;
  logic [NR-1:0][AW-1:0]         req_addr;
  logic [NR-1:0][MW-1:0]         req_mask;
  logic [NR-1:0][MW-1:0][DW-1:0] req_wdata;
  logic [NR-1:0]                 v2;

  logic                  init_done, mem_wen, mem_ren;
  logic [NR-1:0]         req_ready, rsp_valid;
  logic [MW-1:0][DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]         mem_waddr, mem_raddr;
  logic [MW-1:0]         mem_cs;

  logic                  init_done_b, mem_wen_b, mem_ren_b;
  logic [NR-1:0]         req_ready_b, rsp_valid_b;
  logic [MW-1:0][DW-1:0] rsp_rdata_b, mem_wdata_b;
  logic [MW-1:0][DW-1:0] mem_rdata_b = '0;
  logic [AW-1:0]         mem_waddr_b, mem_raddr_b;
  logic [MW-1:0]         mem_cs_b;

  logic [MW-1:0][DW-1:0] mem [DP];

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  syncreadmem_arbiter #(.NUM_REQ(NR), .DEEPTH(DP), .DATA_WIDTH(DW),
                        .WMASK_WIDTH(MW), .ADDR_WIDTH(AW), .INIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_cs(mem_cs), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  syncreadmem_arbiter #(.NUM_REQ(NR), .DEEPTH(DP), .DATA_WIDTH(DW),
                        .WMASK_WIDTH(MW), .ADDR_WIDTH(AW), .INIT_EN(1'b0)) dut_noinit (
    .clk(clk), .rst_n(rst_n), .clear(clear), .init_done(init_done_b),
    .req_valid(v2), .req_ready(req_ready_b), .req_wen(req_wen),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .mem_wen(mem_wen_b), .mem_waddr(mem_waddr_b), .mem_cs(mem_cs_b), .mem_wdata(mem_wdata_b),
    .mem_ren(mem_ren_b), .mem_raddr(mem_raddr_b), .mem_rdata(mem_rdata_b)
  );

  // Synchronous-read memory model; fill preloads all ones so the sweep is visible.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DP; i++) mem[i] <= '1;
    end else if (mem_wen) begin
      for (int l = 0; l < MW; l++) if (mem_cs[l]) mem[mem_waddr][l] <= mem_wdata[l];
    end
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = 2'b11;
    req_wen   = 2'b00;
    req_addr  = '0;
    req_mask  = '0;
    req_wdata = '0;
    v2        = 2'b01;

    // Reset held
    repeat (3) @(posedge clk);
    #3;
    check_val("rst_wen", {31'd0, mem_wen}, 32'd0);
    check_val("rst_ren", {31'd0, mem_ren}, 32'd0);
    check_val("rst_done", {31'd0, init_done}, 32'd0);
    check_val("rst_ready", {30'd0, req_ready}, 32'd0);
    check_val("rst_rspv", {30'd0, rsp_valid}, 32'd0);
    check_val("rst_done_noinit", {31'd0, init_done_b}, 32'd1);
    check_val("rst_ready_noinit", {30'd0, req_ready_b}, 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill  = 1'b0;

    // Sweep after reset: cycles 0..15; clear is ignored here
    for (int k = 0; k < DP; k++) begin
      clear = (k == 3);
      #2;
      check_val("sweep_wen", {31'd0, mem_wen}, 32'd1);
      check_val("sweep_addr", {28'd0, mem_waddr}, k);
      check_val("sweep_cs", {28'd0, mem_cs}, 32'hF);
      check_val("sweep_wdata", {24'd0, mem_wdata}, 32'd0);
      check_val("sweep_ready", {30'd0, req_ready}, 32'd0);
      check_val("sweep_done", {31'd0, init_done}, 32'd0);
      if (k == 0) begin
        check_val("noinit_done_c0", {31'd0, init_done_b}, 32'd1);
        check_val("noinit_grant_c0", {30'd0, req_ready_b}, 32'd1);
      end
      tick();
    end
    clear = 1'b0;

    // Cycle 16: idle, read address 5 from requester 0
    req_valid = 2'b01; req_wen = 2'b00; req_addr[0] = 4'd5;
    #2;
    check_val("done_c16", {31'd0, init_done}, 32'd1);
    check_val("rd5_ready", {30'd0, req_ready}, 32'd1);
    check_val("rd5_ren", {31'd0, mem_ren}, 32'd1);
    check_val("rd5_raddr", {28'd0, mem_raddr}, 32'd5);
    check_val("rd5_wen", {31'd0, mem_wen}, 32'd0);
    tick();

    // Cycle 17: read response; requester 0 writes address 3, mask 0101
    req_valid = 2'b01; req_wen = 2'b01; req_addr[0] = 4'd3;
    req_mask[0] = 4'b0101; req_wdata[0] = 8'hE4;
    #2;
    check_val("rd5_rspv", {30'd0, rsp_valid}, 32'd1);
    check_val("rd5_data", {24'd0, rsp_rdata}, 32'd0);
    check_val("wr3_ready", {30'd0, req_ready}, 32'd1);
    check_val("wr3_wen", {31'd0, mem_wen}, 32'd1);
    check_val("wr3_addr", {28'd0, mem_waddr}, 32'd3);
    check_val("wr3_cs", {28'd0, mem_cs}, 32'd5);
    check_val("wr3_wdata", {24'd0, mem_wdata}, 32'hE4);
    check_val("wr3_ren", {31'd0, mem_ren}, 32'd0);
    tick();

    // Cycle 18: requester 1 reads address 3
    req_valid = 2'b10; req_wen = 2'b00; req_addr[1] = 4'd3;
    #2;
    check_val("rd3_ready", {30'd0, req_ready}, 32'd2);
    check_val("rd3_ren", {31'd0, mem_ren}, 32'd1);
    check_val("rd3_raddr", {28'd0, mem_raddr}, 32'd3);
    check_val("rd3_wen", {31'd0, mem_wen}, 32'd0);
    check_val("wr_no_rspv", {30'd0, rsp_valid}, 32'd0);
    tick();

    // Cycles 19..24: both valid, grants alternate
    req_valid = 2'b11; req_addr = '0;
    for (int j = 0; j < 6; j++) begin
      #2;
      check_val("rr_ready", {30'd0, req_ready}, (j % 2 == 0) ? 32'd1 : 32'd2);
      check_val("rr_rspv", {30'd0, rsp_valid}, (j % 2 == 1) ? 32'd1 : 32'd2);
      if (j == 0) check_val("rd3_data", {24'd0, rsp_rdata}, 32'h20);
      tick();
    end

    // Cycle 25: clear right after a read grant
    clear = 1'b1;
    #2;
    check_val("clr_ready", {30'd0, req_ready}, 32'd0);
    check_val("clr_rspv", {30'd0, rsp_valid}, 32'd2);
    check_val("clr_wen", {31'd0, mem_wen}, 32'd0);
    check_val("clr_ren", {31'd0, mem_ren}, 32'd0);
    tick();
    clear = 1'b0;

    // Cycles 26..41: sweep triggered by clear
    for (int k = 0; k < DP; k++) begin
      #2;
      check_val("csw_ready", {30'd0, req_ready}, 32'd0);
      check_val("csw_wen", {31'd0, mem_wen}, 32'd1);
      check_val("csw_addr", {28'd0, mem_waddr}, k);
      check_val("csw_done", {31'd0, init_done}, 32'd0);
      if (k == 0) check_val("csw_rspv", {30'd0, rsp_valid}, 32'd0);
      tick();
    end

    // Cycle 42: read address 3 again, must be zero
    req_valid = 2'b01; req_wen = 2'b00; req_addr[0] = 4'd3;
    #2;
    check_val("csw_done_end", {31'd0, init_done}, 32'd1);
    check_val("rd3b_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    #2;
    check_val("rd3b_rspv", {30'd0, rsp_valid}, 32'd1);
    check_val("rd3b_data", {24'd0, rsp_rdata}, 32'd0);
    tick();

    // Start another sweep and reset it at address 7
    clear = 1'b1;
    #2;
    check_val("clr2_ready", {30'd0, req_ready}, 32'd0);
    tick();
    clear = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #2;
      check_val("msw_addr", {28'd0, mem_waddr}, k);
      if (k != 7) tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mrst_wen", {31'd0, mem_wen}, 32'd0);
    check_val("mrst_done", {31'd0, init_done}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < DP; k++) begin
      #2;
      check_val("rsw_wen", {31'd0, mem_wen}, 32'd1);
      check_val("rsw_addr", {28'd0, mem_waddr}, k);
      check_val("rsw_done", {31'd0, init_done}, 32'd0);
      tick();
    end
    #2;
    check_val("rsw_done_end", {31'd0, init_done}, 32'd1);
    check_val("rsw_wen_end", {31'd0, mem_wen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/syncreadmem_arbiter.md
# syncreadmem_arbiter

Controller that shares one `SyncReadMem` instance between `NUM_REQ` requesters and zero-initialises it after reset or on `clear`. It grants at most one access per cycle, either a read or a masked write, in round-robin order. Read data is routed back with the memory's 1-cycle latency. It sits directly in front of a cache data or tag array and drives both memory channels.

## Interface
- `NUM_REQ`, 2: number of requesters (≥1).
- `DEEPTH`, 2048: memory depth.
- `DATA_WIDTH`, 2: bits per mask lane.
- `WMASK_WIDTH`, 4: mask lanes per word.
- `ADDR_WIDTH`, `$clog2(DEEPTH)`: address width.
- `INIT_EN`, 1: run the zero-fill sweep after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: pulse; re-runs the zero-fill sweep (honoured only in IDLE).
- `init_done` out 1: high in IDLE.
- `req_valid` in [NUM_REQ]: request valid.
- `req_ready` out [NUM_REQ]: grant; one-hot or zero.
- `req_wen` in [NUM_REQ]: 1 = write, 0 = read.
- `req_addr` in [NUM_REQ][ADDR_WIDTH]: address.
- `req_mask` in [NUM_REQ][WMASK_WIDTH]: write lane enables.
- `req_wdata` in [NUM_REQ][WMASK_WIDTH][DATA_WIDTH]: write data.
- `rsp_valid` out [NUM_REQ]: read data valid for that requester.
- `rsp_rdata` out [WMASK_WIDTH][DATA_WIDTH]: read data, broadcast to all requesters.
- `mem_wen`, `mem_waddr`, `mem_cs`, `mem_wdata` out: memory write channel.
- `mem_ren`, `mem_raddr` out: memory read channel.
- `mem_rdata` in: memory read data.

## Operation
- **States:** ARB_INIT, ARB_IDLE.
- **Reset state:** ARB_INIT if `INIT_EN`, otherwise ARB_IDLE.
- **ARB_INIT:**
  - Counter `init_addr` starts at 0.
  - Each cycle drives `mem_wen`=1, `mem_waddr`=`init_addr`, `mem_cs`=all ones, `mem_wdata`=0.
  - `init_addr` increments each cycle.
  - When `init_addr`==DEEPTH-1 the state moves to ARB_IDLE next cycle. The compare handles non-power-of-2 DEEPTH.
  - `req_ready` is 0 throughout; `clear` is ignored.
- **ARB_IDLE, granting:**
  - A round-robin arbiter picks the first valid requester at or after pointer `rr_ptr`.
  - `req_ready[g]`=1 for that requester only. `req_ready` depends combinationally on `req_valid`.
  - After a grant, `rr_ptr` becomes (g+1) mod NUM_REQ. With no grant it is unchanged.
- **Granted write:** `mem_wen`=1, `mem_waddr`=`req_addr[g]`, `mem_cs`=`req_mask[g]`, `mem_wdata`=`req_wdata[g]`, `mem_ren`=0.
- **Granted read:** `mem_ren`=1, `mem_raddr`=`req_addr[g]`, `mem_wen`=0.
  - A registered one-hot `rsp_sel` records g.
  - Next cycle `rsp_valid` = `rsp_sel`.
- **Routing:** `rsp_rdata` = `mem_rdata`, passed straight through.
- **Concurrency:** a read and a write are never issued in the same cycle, so the memory's same-address forwarding path is never exercised.
- **clear in ARB_IDLE:** no grant that cycle. Next state is ARB_INIT with `init_addr`=0. A read granted in the previous cycle still gets its `rsp_valid`.
- **Idle outputs:** with no grant, `mem_wen`=`mem_ren`=0 and addresses/data are don't-care (hold 0).

## Timing
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_sel`=0, `rr_ptr`=0, `init_addr`=0.
  - `init_done`=0 if `INIT_EN`, else 1.
  - `mem_wen`/`mem_ren` are 0 while `rst_n` is low.
  - The first sweep write occurs on the first rising edge after `rst_n` deasserts.
- **Sweep duration:** exactly DEEPTH cycles; `init_done` rises the cycle after the last write.
- **Read latency:** `rsp_valid` and data arrive 1 cycle after the `req_valid` & `req_ready` handshake.
- **Throughput:** one access per cycle with back-to-back grants.
- **Reset mid-sweep:** asynchronous return to ARB_INIT with `init_addr`=0. A pending `rsp_valid` is dropped.
- **Fairness:** with all requesters valid, each is granted once every NUM_REQ cycles.

## Structure
- **Package `syncreadmem_arb_pkg`:** `arb_state_e` {ARB_INIT, ARB_IDLE}.
- **Sub-module `rr_arbiter`:**
  - Parameterised by NUM_REQ.
  - Inputs: `clk`, `rst_n`, `valid`, `advance`.
  - Outputs: one-hot `grant`, `grant_idx`.
  - Owns `rr_ptr`.
- **Top level:** owns the FSM, the init counter, the memory mux, and `rsp_sel`.

## Test plan
- DEEPTH=16, INIT_EN=1, release reset -> 16 writes to addresses 0..15 with `cs`=4'hF and data 0, then `init_done`=1 at cycle 16; read of address 5 returns all lanes 0.
- Requester 0 writes address 3, mask 4'b0101, data {3,2,1,0}; requester 1 reads address 3 next cycle -> `rsp_valid`=2'b10 one cycle later, lanes {0,2,0,0}.
- Both requesters hold `req_valid` for 6 cycles -> `req_ready` alternates 01,10,01,10,01,10.
- `clear` pulsed in the same cycle as a read grant from the prior cycle -> that read's `rsp_valid` is still delivered; then 16 sweep cycles with `req_ready`=0; reads afterward return 0.
- `rst_n` asserted at sweep address 7 -> after release the sweep restarts at address 0 and runs the full 16 cycles.
- INIT_EN=0 -> `init_done`=1 straight out of reset, and the first request is granted in cycle 0.
